// File: rtl/mcu_sched_pkg.sv
// Shared types for the MCU job scheduler.
// FSM state and result status encodings.
package mcu_sched_pkg;

  localparam int unsigned RES_ID_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_RUN       = 3'd4,
    ST_REPORT    = 3'd5
  } sched_state_e;

  typedef enum logic [1:0] {
    RES_OK      = 2'd0,
    RES_ERR     = 2'd1,
    RES_TIMEOUT = 2'd2,
    RES_ABORT   = 2'd3
  } res_status_e;

  function automatic int unsigned max_u(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mcu_job_fifo.sv
// Job queue for the MCU scheduler.
// Power-of-two FIFO with occupancy count and flush.
module mcu_job_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Pointer and occupancy update; flush empties the queue at once
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written on accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mcu_job_scheduler.sv
// Job scheduler in front of a memory control unit.
// Queues jobs, issues them, retries, times out and reports.
module mcu_job_scheduler
  import mcu_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH_DATA  = 32,
  parameter int unsigned ADDR_WIDTH_GRID  = 32,
  parameter int unsigned ADDR_WIDTH_SCALE = 32,
  parameter int unsigned QUEUE_DEPTH      = 4,
  parameter int unsigned MAX_RETRIES      = 1,
  parameter int unsigned START_TIMEOUT    = 16,
  parameter int unsigned RUN_TIMEOUT      = 65535
) (
  input  logic                          fsm_clk,
  input  logic                          rst,
  input  logic                          s_job_valid,
  output logic                          s_job_ready,
  input  logic [ADDR_WIDTH_DATA:0]      s_job_data_size,
  input  logic [ADDR_WIDTH_GRID:0]      s_job_grid_size,
  input  logic [ADDR_WIDTH_SCALE:0]     s_job_scle_size,
  output logic                          operation_start,
  output logic [ADDR_WIDTH_DATA:0]      data_size,
  output logic [ADDR_WIDTH_GRID:0]      grid_size,
  output logic [ADDR_WIDTH_SCALE:0]     scle_size,
  input  logic                          operation_busy,
  input  logic                          operation_complete,
  input  logic                          operation_error,
  output logic                          m_res_valid,
  input  logic                          m_res_ready,
  output logic [7:0]                    m_res_id,
  output logic [1:0]                    m_res_status,
  input  logic                          abort,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count,
  output logic                          sched_busy
);

  localparam int unsigned DW    = ADDR_WIDTH_DATA + 1;
  localparam int unsigned GW    = ADDR_WIDTH_GRID + 1;
  localparam int unsigned SW    = ADDR_WIDTH_SCALE + 1;
  localparam int unsigned FW    = DW + GW + SW;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned RTY_W = $clog2(MAX_RETRIES + 2);
  localparam int unsigned TMR_W =
    $clog2(max_u(START_TIMEOUT, RUN_TIMEOUT) + 1);

  sched_state_e         state_q, state_d;
  res_status_e          res_status_q, res_status_d;
  logic [DW-1:0]        data_size_q, data_size_d;
  logic [GW-1:0]        grid_size_q, grid_size_d;
  logic [SW-1:0]        scle_size_q, scle_size_d;
  logic [RES_ID_W-1:0]  id_q, id_d;
  logic [RES_ID_W-1:0]  job_ctr_q, job_ctr_d;
  logic [RTY_W-1:0]     retry_cnt_q, retry_cnt_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 abort_pend_q, abort_pend_d;
  logic                 op_start_q, op_start_d;
  logic                 res_valid_q, res_valid_d;
  logic                 sched_busy_q, sched_busy_d;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FW-1:0]        fifo_dout;
  logic [CNT_W-1:0]     fifo_count;

  mcu_job_fifo #(
    .WIDTH (FW),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (fsm_clk),
    .rst   (rst),
    .flush (abort),
    .push  (s_job_valid),
    .din   ({s_job_data_size, s_job_grid_size, s_job_scle_size}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign s_job_ready     = !fifo_full;
  assign queue_count     = fifo_count;
  assign operation_start = op_start_q;
  assign data_size       = data_size_q;
  assign grid_size       = grid_size_q;
  assign scle_size       = scle_size_q;
  assign m_res_valid     = res_valid_q;
  assign m_res_id        = id_q;
  assign m_res_status    = res_status_q;
  assign sched_busy      = sched_busy_q;

  // Next-state and datapath; outputs derive from the next state
  always_comb begin
    state_d      = state_q;
    res_status_d = res_status_q;
    data_size_d  = data_size_q;
    grid_size_d  = grid_size_q;
    scle_size_d  = scle_size_q;
    id_d         = id_q;
    job_ctr_d    = job_ctr_q;
    retry_cnt_d  = retry_cnt_q;
    timer_d      = timer_q;
    abort_pend_d = abort_pend_q;
    fifo_pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (!fifo_empty && !abort) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          fifo_pop     = 1'b1;
          {data_size_d, grid_size_d, scle_size_d} = fifo_dout;
          id_d         = job_ctr_q;
          job_ctr_d    = job_ctr_q + 8'd1;
          retry_cnt_d  = '0;
          abort_pend_d = 1'b0;
          state_d      = ST_START;
        end
      end
      ST_START: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = TMR_W'(1);
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY, ST_RUN: begin
        if (abort || abort_pend_q) begin
          if (!operation_busy) begin
            abort_pend_d = 1'b0;
            res_status_d = RES_ABORT;
            state_d      = ST_REPORT;
          end else begin
            abort_pend_d = 1'b1;
          end
        end else if (operation_error) begin
          if (retry_cnt_q < RTY_W'(MAX_RETRIES)) begin
            retry_cnt_d = retry_cnt_q + RTY_W'(1);
            state_d     = ST_START;
          end else begin
            res_status_d = RES_ERR;
            state_d      = ST_REPORT;
          end
        end else if (state_q == ST_WAIT_BUSY) begin
          if (operation_busy) begin
            timer_d = TMR_W'(1);
            state_d = ST_RUN;
          end else if (timer_q >= TMR_W'(START_TIMEOUT - 1)) begin
            res_status_d = RES_TIMEOUT;
            state_d      = ST_REPORT;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end else begin
          if (operation_complete) begin
            res_status_d = RES_OK;
            state_d      = ST_REPORT;
          end else if (timer_q >= TMR_W'(RUN_TIMEOUT)) begin
            res_status_d = RES_TIMEOUT;
            state_d      = ST_REPORT;
          end else if (operation_busy) begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      ST_REPORT: begin
        if (m_res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    op_start_d   = (state_d == ST_START);
    res_valid_d  = (state_d == ST_REPORT);
    sched_busy_d = (state_d != ST_IDLE);
  end

  // FSM state and registered outputs
  always_ff @(posedge fsm_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      res_status_q <= RES_OK;
      data_size_q  <= '0;
      grid_size_q  <= '0;
      scle_size_q  <= '0;
      id_q         <= '0;
      job_ctr_q    <= '0;
      retry_cnt_q  <= '0;
      timer_q      <= '0;
      abort_pend_q <= 1'b0;
      op_start_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      sched_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      res_status_q <= res_status_d;
      data_size_q  <= data_size_d;
      grid_size_q  <= grid_size_d;
      scle_size_q  <= scle_size_d;
      id_q         <= id_d;
      job_ctr_q    <= job_ctr_d;
      retry_cnt_q  <= retry_cnt_d;
      timer_q      <= timer_d;
      abort_pend_q <= abort_pend_d;
      op_start_q   <= op_start_d;
      res_valid_q  <= res_valid_d;
      sched_busy_q <= sched_busy_d;
    end
  end

endmodule
